// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the per-axis phase type used by
// the VGA sync generator and its axis counters.
package vga_timing_pkg;

    // Default 640x480@60 geometry (pixels / lines).
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Derived totals: 800 pixels per line, 525 lines per frame.
    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync windows, start inclusive / end exclusive.
    localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    // Width of the x/y counters; 10 bits covers both 800 and 525.
    localparam int COUNT_W = 10;

    // Phase of one raster axis.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } axis_phase_t;

    // Map "sync window active" to the pin level for the chosen polarity.
    function automatic logic sync_level(input logic asserted, input bit pol);
        return asserted ? logic'(pol) : logic'(~pol);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus a four-phase
// ACTIVE -> FRONT -> SYNC -> BACK state machine that tracks which region
// the counter will occupy after the current edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = H_ACTIVE_DEF,
    parameter int FRONT_LEN  = H_FP_DEF,
    parameter int SYNC_LEN   = H_SYNC_DEF,
    parameter int BACK_LEN   = H_BP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    output logic [COUNT_W-1:0] count,
    output axis_phase_t        phase,
    output logic               wrap
);

    // Last count of each phase; the phase changes when leaving these values.
    localparam logic [COUNT_W-1:0] ACTIVE_LAST = COUNT_W'(ACTIVE_LEN - 1);
    localparam logic [COUNT_W-1:0] FRONT_LAST  = COUNT_W'(ACTIVE_LEN + FRONT_LEN - 1);
    localparam logic [COUNT_W-1:0] SYNC_LAST   = COUNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
    localparam logic [COUNT_W-1:0] TOTAL_LAST  = COUNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);

    logic [COUNT_W-1:0] count_reg;
    axis_phase_t        phase_reg;
    axis_phase_t        phase_next;

    // Wrap fires on the advancing edge that takes the counter back to 0.
    assign wrap  = adv && (count_reg == TOTAL_LAST);
    assign count = count_reg;

    // The phase port is the phase being loaded on this edge, so the parent
    // can register decoded outputs in lockstep with the counter itself.
    assign phase = phase_next;

    // Phase transitions happen only when advancing out of a phase's last count.
    always_comb begin
        phase_next = phase_reg;
        if (adv) begin
            case (phase_reg)
                PH_ACTIVE: if (count_reg == ACTIVE_LAST) phase_next = PH_FRONT;
                PH_FRONT:  if (count_reg == FRONT_LAST)  phase_next = PH_SYNC;
                PH_SYNC:   if (count_reg == SYNC_LAST)   phase_next = PH_BACK;
                PH_BACK:   if (count_reg == TOTAL_LAST)  phase_next = PH_ACTIVE;
                default:                                 phase_next = PH_ACTIVE;
            endcase
        end
    end

    // Counter and phase state; reset returns to the start of the active region.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            phase_reg <= PH_ACTIVE;
        end else begin
            phase_reg <= phase_next;
            if (adv) begin
                count_reg <= wrap ? '0 : count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: two chained axis counters advanced by the
// pixel-rate qualifier, with sync, active-video and line/frame strobes
// registered alongside the counters so every output refers to the same
// pixel position.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COUNT_W-1:0] x,
    output logic [COUNT_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
);

    axis_phase_t h_phase;
    axis_phase_t v_phase;
    logic        h_wrap;
    logic        v_wrap;
    logic        v_adv;

    logic hsync_reg;
    logic vsync_reg;
    logic active_reg;
    logic line_start_reg;
    logic frame_start_reg;

    // The vertical axis steps on the same edge the horizontal one wraps.
    assign v_adv = pix_en && h_wrap;

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FRONT_LEN  (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BP)
    ) u_h_counter (
        .clk   (clk),
        .rst   (rst),
        .adv   (pix_en),
        .count (x),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FRONT_LEN  (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_BP)
    ) u_v_counter (
        .clk   (clk),
        .rst   (rst),
        .adv   (v_adv),
        .count (y),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    // Decode the phases being loaded this edge so outputs match the new x/y;
    // strobes are the wrap events of this edge, so they last one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            active_reg      <= 1'b1;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            hsync_reg       <= sync_level(h_phase == PH_SYNC, SYNC_POL);
            vsync_reg       <= sync_level(v_phase == PH_SYNC, SYNC_POL);
            active_reg      <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            line_start_reg  <= h_wrap;
            frame_start_reg <= v_wrap;
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign active      = active_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed testbench for vga_sync_gen: a full-size 640x480 instance for
// line-level behaviour and a tiny-geometry, active-high-sync instance for
// full frame wrap and vsync timing.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_en = 1'b0;

    logic       hsync, vsync, active, line_start, frame_start;
    logic [9:0] x, y;

    logic       hsync_s, vsync_s, active_s, line_start_s, frame_start_s;
    logic [9:0] x_s, y_s;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Tiny geometry: H 8/2/3/2 (15), V 6/2/2/3 (13), 195 pixels per frame.
    localparam int S_HT = 15;
    localparam int S_VT = 13;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b1)
    ) dut_small (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .active      (active_s),
        .x           (x_s),
        .y           (y_s),
        .line_start  (line_start_s),
        .frame_start (frame_start_s)
    );

    // Drive pix_en for one clk away from the edge, then sample 1 ns after it.
    task automatic tick(input logic pe);
        @(negedge clk);
        pix_en = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick(1'b1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (x !== 10'd0) $display("FAIL reset_x got %0d want 0", x); else pass_cnt++;
        total_cnt++; if (y !== 10'd0) $display("FAIL reset_y got %0d want 0", y); else pass_cnt++;
        total_cnt++; if (active !== 1'b1) $display("FAIL reset_active got %b want 1", active); else pass_cnt++;
        total_cnt++; if (hsync !== 1'b1) $display("FAIL reset_hsync got %b want 1", hsync); else pass_cnt++;
        total_cnt++; if (vsync !== 1'b1) $display("FAIL reset_vsync got %b want 1", vsync); else pass_cnt++;
        total_cnt++; if (line_start !== 1'b0) $display("FAIL reset_line_start got %b want 0", line_start); else pass_cnt++;
        total_cnt++; if (frame_start !== 1'b0) $display("FAIL reset_frame_start got %b want 0", frame_start); else pass_cnt++;
        total_cnt++; if (hsync_s !== 1'b0) $display("FAIL reset_hsync_pos got %b want 0", hsync_s); else pass_cnt++;
        total_cnt++; if (vsync_s !== 1'b0) $display("FAIL reset_vsync_pos got %b want 0", vsync_s); else pass_cnt++;
        tick(1'b0);
        total_cnt++; if (x !== 10'd0) $display("FAIL reset_hold_x got %0d want 0", x); else pass_cnt++;
        $display("test_reset done: x=%0d y=%0d active=%b hsync=%b vsync=%b", x, y, active, hsync, vsync);
    endtask

    task automatic test_line_wrap();
        int ex, ey;
        do_reset();
        for (int n = 1; n <= 800; n++) begin
            tick(1'b1);
            ex = n % 800;
            ey = n / 800;
            total_cnt++; if (x !== 10'(ex)) $display("FAIL wrap_x n=%0d got %0d want %0d", n, x, ex); else pass_cnt++;
            total_cnt++; if (y !== 10'(ey)) $display("FAIL wrap_y n=%0d got %0d want %0d", n, y, ey); else pass_cnt++;
            total_cnt++; if (active !== logic'(ex < 640)) $display("FAIL wrap_active n=%0d got %b want %b", n, active, ex < 640); else pass_cnt++;
            total_cnt++; if (line_start !== logic'(n == 800)) $display("FAIL wrap_line_start n=%0d got %b want %b", n, line_start, n == 800); else pass_cnt++;
            repeat (3) begin
                tick(1'b0);
                total_cnt++; if (line_start !== 1'b0) $display("FAIL wrap_gap_line_start n=%0d got %b want 0", n, line_start); else pass_cnt++;
                total_cnt++; if (x !== 10'(ex)) $display("FAIL wrap_gap_x n=%0d got %0d want %0d", n, x, ex); else pass_cnt++;
            end
        end
        $display("test_line_wrap done: x=%0d y=%0d", x, y);
    endtask

    task automatic test_hsync_window();
        int ex;
        int low_cnt = 0;
        do_reset();
        for (int n = 1; n <= 2400; n++) begin
            tick(1'b1);
            ex = n % 800;
            if (hsync === 1'b0) low_cnt++;
            total_cnt++; if (hsync !== logic'(!(ex >= 656 && ex < 752))) $display("FAIL hsync_win n=%0d x=%0d got %b", n, x, hsync); else pass_cnt++;
            total_cnt++; if (vsync !== 1'b1) $display("FAIL hsync_vsync n=%0d got %b want 1", n, vsync); else pass_cnt++;
        end
        total_cnt++; if (low_cnt != 288) $display("FAIL hsync_low_count got %0d want 288", low_cnt); else pass_cnt++;
        $display("test_hsync_window done: hsync low for %0d pixels over 3 lines", low_cnt);
    endtask

    task automatic test_hold();
        int gaps [3] = '{1, 3, 10};
        int n = 0;
        int ex;
        logic [9:0] snap_x;
        logic       snap_h, snap_a;
        do_reset();
        for (int seg = 0; seg < 2; seg++) begin
            while (n < (seg == 0 ? 650 : 795)) begin
                tick(1'b1);
                n++;
            end
            for (int k = 0; k < 12; k++) begin
                tick(1'b1);
                n++;
                ex = n % 800;
                total_cnt++; if (x !== 10'(ex)) $display("FAIL hold_x n=%0d got %0d want %0d", n, x, ex); else pass_cnt++;
                total_cnt++; if (hsync !== logic'(!(ex >= 656 && ex < 752))) $display("FAIL hold_hsync n=%0d got %b", n, hsync); else pass_cnt++;
                total_cnt++; if (line_start !== logic'(ex == 0)) $display("FAIL hold_line_start n=%0d got %b want %b", n, line_start, ex == 0); else pass_cnt++;
                snap_x = x; snap_h = hsync; snap_a = active;
                repeat (gaps[k % 3]) begin
                    tick(1'b0);
                    total_cnt++;
                    if (x !== snap_x || hsync !== snap_h || active !== snap_a || line_start !== 1'b0)
                        $display("FAIL hold_gap n=%0d got x=%0d h=%b a=%b ls=%b want x=%0d h=%b a=%b ls=0",
                                 n, x, hsync, active, line_start, snap_x, snap_h, snap_a);
                    else pass_cnt++;
                end
            end
        end
        $display("test_hold done: x=%0d y=%0d after %0d strobes", x, y, n);
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        repeat (2700) tick(1'b1);
        total_cnt++; if (x !== 10'd300 || y !== 10'd3) $display("FAIL mid_pos got (%0d,%0d) want (300,3)", x, y); else pass_cnt++;
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        total_cnt++; if (x !== 10'd0 || y !== 10'd0) $display("FAIL mid_rst_xy got (%0d,%0d) want (0,0)", x, y); else pass_cnt++;
        total_cnt++;
        if (active !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1 || line_start !== 1'b0 || frame_start !== 1'b0)
            $display("FAIL mid_rst_flags got a=%b h=%b v=%b ls=%b fs=%b want 1 1 1 0 0",
                     active, hsync, vsync, line_start, frame_start);
        else pass_cnt++;
        tick(1'b1);
        total_cnt++; if (x !== 10'd1 || y !== 10'd0) $display("FAIL mid_first_px got (%0d,%0d) want (1,0)", x, y); else pass_cnt++;
        $display("test_reset_mid_frame done: x=%0d y=%0d", x, y);
    endtask

    task automatic test_frame_wrap();
        int ex, ey;
        int vs_cnt = 0;
        do_reset();
        for (int n = 1; n <= S_HT * S_VT; n++) begin
            tick(1'b1);
            ex = n % S_HT;
            ey = (n / S_HT) % S_VT;
            if (vsync_s === 1'b1) vs_cnt++;
            total_cnt++; if (x_s !== 10'(ex) || y_s !== 10'(ey)) $display("FAIL frame_xy n=%0d got (%0d,%0d) want (%0d,%0d)", n, x_s, y_s, ex, ey); else pass_cnt++;
            total_cnt++; if (hsync_s !== logic'(ex >= 10 && ex < 13)) $display("FAIL frame_hsync n=%0d got %b", n, hsync_s); else pass_cnt++;
            total_cnt++; if (vsync_s !== logic'(ey >= 8 && ey < 10)) $display("FAIL frame_vsync n=%0d got %b", n, vsync_s); else pass_cnt++;
            total_cnt++; if (active_s !== logic'(ex < 8 && ey < 6)) $display("FAIL frame_active n=%0d got %b", n, active_s); else pass_cnt++;
            total_cnt++; if (line_start_s !== logic'(ex == 0)) $display("FAIL frame_line_start n=%0d got %b", n, line_start_s); else pass_cnt++;
            total_cnt++; if (frame_start_s !== logic'(n == S_HT * S_VT)) $display("FAIL frame_start n=%0d got %b", n, frame_start_s); else pass_cnt++;
        end
        total_cnt++; if (vs_cnt != 2 * S_HT) $display("FAIL frame_vsync_len got %0d want %0d", vs_cnt, 2 * S_HT); else pass_cnt++;
        tick(1'b0);
        total_cnt++; if (line_start_s !== 1'b0 || frame_start_s !== 1'b0) $display("FAIL frame_strobe_len got ls=%b fs=%b want 0 0", line_start_s, frame_start_s); else pass_cnt++;
        $display("test_frame_wrap done: vsync asserted for %0d pixels", vs_cnt);
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_hsync_window();
        test_hold();
        test_reset_mid_frame();
        test_frame_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
